fetch_unit: RTL

Instruction fetch stage directly upstream of the register file.
- Owns the program counter and drives the instruction-memory request handshake.
- Delivers the fetched instruction plus its PC+8 value into the decode register. The register file uses that PC+8 value as its R15 read value and as the link source (R14 = R15-4).
- Handles decode stalls with a one-entry skid buffer, and handles redirects (branch, or write to PC) with an outstanding-fetch drain.

---
 rtl/fetch_unit_if.sv | 9 +
 rtl/fetch_unit.sv | 73 +++++++
 2 files changed

// File: rtl/fetch_unit_if.sv
// fetch_unit_if: instruction-memory request/response handshake between fetch and imem
interface fetch_unit_if;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   modport master (output imem_req, imem_addr, input imem_ack, imem_rdata);
   modport slave  (input imem_req, imem_addr, output imem_ack, imem_rdata);
endinterface

// File: rtl/fetch_unit.sv
// fetch_unit: PC owner and imem requester feeding the decode register, with skid buffer and redirect drain
module fetch_unit #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0] NOP_INSTR = 32'hE1A0_0000
) (
   input  logic          CLK,
   input  logic          RST_N,
   input  logic          StallD,
   input  logic          Redirect,
   input  logic [31:0]   RedirectTarget,
   fetch_unit_if.master  imem,
   output logic [31:0]   PCF,
   output logic [31:0]   InstrD,
   output logic [31:0]   PCPlus8D,
   output logic          ValidD
);
   localparam logic [1:0] IDLE = 2'd0, FETCH = 2'd1, HOLD = 2'd2, DRAIN = 2'd3;
   logic [1:0]  state;
   logic [31:0] skid_instr, skid_pc8, drain_addr;
   logic        req;
   assign req            = (state == FETCH) || (state == DRAIN);
   assign imem.imem_req  = req;
   assign imem.imem_addr = (state == DRAIN) ? drain_addr : PCF;
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state      <= IDLE;
         PCF        <= RESET_PC;
         InstrD     <= NOP_INSTR;
         PCPlus8D   <= RESET_PC + 32'd8;
         ValidD     <= 1'b0;
         skid_instr <= NOP_INSTR;
         skid_pc8   <= RESET_PC + 32'd8;
         drain_addr <= RESET_PC;
      end else if (Redirect) begin
         // skid is implicitly emptied by leaving HOLD; PCPlus8D is left as-is
         PCF    <= {RedirectTarget[31:2], 2'b00};
         ValidD <= 1'b0;
         InstrD <= NOP_INSTR;
         state  <= (req && !imem.imem_ack) ? DRAIN : FETCH;
         if (state == FETCH) drain_addr <= PCF;
      end else begin
         case (state)
            IDLE: state <= FETCH;
            FETCH: begin
               if (imem.imem_ack) begin
                  PCF <= PCF + 32'd4;
                  if (StallD) begin
                     skid_instr <= imem.imem_rdata;
                     skid_pc8   <= PCF + 32'd8;
                     state      <= HOLD;
                  end else begin
                     InstrD   <= imem.imem_rdata;
                     PCPlus8D <= PCF + 32'd8;
                     ValidD   <= 1'b1;
                  end
               end else if (!StallD) begin
                  ValidD <= 1'b0;
                  InstrD <= NOP_INSTR;
               end
            end
            HOLD: begin
               if (!StallD) begin
                  InstrD   <= skid_instr;
                  PCPlus8D <= skid_pc8;
                  ValidD   <= 1'b1;
                  state    <= FETCH;
               end
            end
            default: if (imem.imem_ack) state <= FETCH;
         endcase
      end
   end
endmodule
